// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 interrupt controller: register indices,
// SR/Cause field positions, FSM state encoding and parameter defaults.
package cp0_pkg;

    // CP0 register indices for mfc0/mtc0
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // SR field positions
    localparam int SR_IM_HI  = 15;
    localparam int SR_IM_LO  = 10;
    localparam int SR_EXL    = 1;
    localparam int SR_IE     = 0;

    // Cause field positions
    localparam int CAUSE_BD    = 31;
    localparam int CAUSE_IP_HI = 15;
    localparam int CAUSE_IP_LO = 10;

    // Parameter defaults
    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
    localparam logic [31:0] PRID_DEF         = 32'h4D49_5053;

    // FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HANDLE = 2'd2
    } cp0_state_e;

    // Word-align an address by clearing its two low bits
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : cp0_pkg

// File: rtl/cp0_int_fsm.sv
// Interrupt sequencing FSM: decides when an interrupt is taken, drives the
// one-cycle pipeline flush and produces the PC redirect for both interrupt
// entry and eret.
module cp0_int_fsm
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        irq_ready_i,    // some enabled source pending, IE=1, EXL=0
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    output logic        take_o,
    output logic        eret_ok_o,      // eret that actually retires (not flushed)
    output logic        int_accept_o,
    output logic        pc_redirect_o,
    output logic [31:0] new_pc_o,
    output logic [1:0]  state_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FLUSH  = 2'd1;
    localparam logic [1:0] HANDLE = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;

    // Take / eret qualification. An eret in the same cycle suppresses the
    // take; an eret seen during FLUSH belongs to an instruction being
    // flushed, so it neither retires nor redirects.
    always_comb begin
        take_o    = irq_ready_i & ~eret_i & (state_q == IDLE);
        eret_ok_o = eret_i & (state_q != FLUSH);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take_o) state_d = FLUSH;
            FLUSH:   state_d = HANDLE;
            HANDLE:  if (eret_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Flush pulse and PC redirect generation
    always_comb begin
        int_accept_o  = 1'b0;
        pc_redirect_o = 1'b0;
        new_pc_o      = 32'h0;
        if (state_q == FLUSH) begin
            int_accept_o  = 1'b1;
            pc_redirect_o = 1'b1;
            new_pc_o      = HANDLER_ADDR;
        end else if (eret_ok_o) begin
            pc_redirect_o = 1'b1;
            new_pc_o      = epc_i;
        end
    end

    assign state_o = state_q;

endmodule : cp0_int_fsm

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller top: holds SR, Cause and EPC, services mfc0/mtc0,
// and hands interrupt sequencing to cp0_int_fsm.
module cp0_int_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter logic [31:0] PRID         = PRID_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IntReq,
    input  logic [4:0]  HWInt,
    input  logic [31:0] PCM,
    input  logic        BDM,
    input  logic [4:0]  A,
    input  logic        We,
    input  logic [31:0] DIn,
    input  logic        ERet,
    output logic [31:0] DOut,
    output logic        IntAccept,
    output logic        PCRedirect,
    output logic [31:0] NewPC,
    output logic [31:0] EPCOut,
    output logic [1:0]  state_dbg
);

    // Architectural state
    logic [5:0]  sr_im_q,    sr_im_d;
    logic        sr_exl_q,   sr_exl_d;
    logic        sr_ie_q,    sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q, cause_ip_d;
    logic [31:0] epc_q,      epc_d;

    logic [5:0]  pend;
    logic        irq_ready;
    logic        take;
    logic        eret_ok;
    logic [31:0] trap_pc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    // Pending sources and interrupt readiness (state gating done in the FSM)
    always_comb begin
        pend      = {HWInt, IntReq};
        irq_ready = (|(pend & sr_im_q)) & sr_ie_q & ~sr_exl_q;
        // A delay-slot instruction restarts at its branch; PCM-4 wraps mod 2^32
        trap_pc   = word_align(BDM ? (PCM - 32'd4) : PCM);
    end

    cp0_int_fsm #(
        .HANDLER_ADDR (HANDLER_ADDR)
    ) u_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_ready_i   (irq_ready),
        .eret_i        (ERet),
        .epc_i         (epc_q),
        .take_o        (take),
        .eret_ok_o     (eret_ok),
        .int_accept_o  (IntAccept),
        .pc_redirect_o (PCRedirect),
        .new_pc_o      (NewPC),
        .state_o       (state_dbg)
    );

    // Next-value logic for SR, Cause and EPC. A take discards any
    // coincident mtc0 because that instruction re-executes from EPC.
    always_comb begin
        sr_im_d    = sr_im_q;
        sr_exl_d   = sr_exl_q;
        sr_ie_d    = sr_ie_q;
        cause_bd_d = cause_bd_q;
        cause_ip_d = pend;
        epc_d      = epc_q;

        if (take) begin
            epc_d      = trap_pc;
            cause_bd_d = BDM;
            sr_exl_d   = 1'b1;
        end else begin
            if (We && (A == CP0_SR)) begin
                sr_im_d  = DIn[SR_IM_HI:SR_IM_LO];
                sr_exl_d = DIn[SR_EXL];
                sr_ie_d  = DIn[SR_IE];
            end
            if (We && (A == CP0_EPC)) begin
                epc_d = word_align(DIn);
            end
            // eret wins over a same-cycle SR write for EXL only
            if (eret_ok) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    // Register update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_im_q    <= 6'h0;
            sr_exl_q   <= 1'b0;
            sr_ie_q    <= 1'b0;
            cause_bd_q <= 1'b0;
            cause_ip_q <= 6'h0;
            epc_q      <= 32'h0;
        end else begin
            sr_im_q    <= sr_im_d;
            sr_exl_q   <= sr_exl_d;
            sr_ie_q    <= sr_ie_d;
            cause_bd_q <= cause_bd_d;
            cause_ip_q <= cause_ip_d;
            epc_q      <= epc_d;
        end
    end

    // mfc0 read mux; unused bits read as zero
    always_comb begin
        sr_word    = {16'h0, sr_im_q, 8'h0, sr_exl_q, sr_ie_q};
        cause_word = {cause_bd_q, 15'h0, cause_ip_q, 10'h0};
        case (A)
            CP0_SR:    DOut = sr_word;
            CP0_CAUSE: DOut = cause_word;
            CP0_EPC:   DOut = epc_q;
            CP0_PRID:  DOut = PRID;
            default:   DOut = 32'h0;
        endcase
    end

    assign EPCOut = epc_q;

endmodule : cp0_int_ctrl
